// File: rtl/exe_hazard_unit_pkg.sv
// Shared CPU package: hazard FSM states, operand forwarding codes and
// register-number helpers used by the EXE hazard unit.
package exe_hazard_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_REG  = 2'd0,
    FWD_EXE  = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_LOAD = 2'd3
  } fwd_e;

  // A destination matches a source only for a real (non-zero) register.
  function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/exe_hazard_unit_if.sv
// Bundle of ID/EXE/MEM hazard inputs and forwarding/stall outputs.
// master: pipeline side driving stage info; slave: the hazard unit.
interface exe_hazard_unit_if;
  import exe_hazard_unit_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] exe_rn;
  logic             exe_wreg;
  logic             exe_m2reg;
  logic [REG_W-1:0] mem_rn;
  logic             mem_wreg;
  logic             mem_m2reg;
  logic             id_branch_taken;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             wpcir;
  logic             id_bubble;
  logic             if_flush;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
           exe_rn, exe_wreg, exe_m2reg,
           mem_rn, mem_wreg, mem_m2reg, id_branch_taken,
    input  fwda, fwdb, wpcir, id_bubble, if_flush
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
           exe_rn, exe_wreg, exe_m2reg,
           mem_rn, mem_wreg, mem_m2reg, id_branch_taken,
    output fwda, fwdb, wpcir, id_bubble, if_flush
  );

endinterface

// File: rtl/exe_hazard_unit_fwd_select.sv
// Per-operand forwarding source select. EXE ALU result wins over MEM;
// a load still in EXE is never forwarded (the stall covers it).
module fwd_select
  import exe_hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] exe_rn,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [REG_W-1:0] mem_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  output fwd_e             fwd
);

  // Priority compare: EXE ALU, then MEM (ALU or load data), else regfile.
  always_comb begin
    fwd = FWD_REG;
    if (exe_wreg && !exe_m2reg && reg_hit(exe_rn, src)) begin
      fwd = FWD_EXE;
    end else if (mem_wreg && reg_hit(mem_rn, src)) begin
      fwd = mem_m2reg ? FWD_LOAD : FWD_MEM;
    end
  end

endmodule

// File: rtl/exe_hazard_unit.sv
// EXE-stage hazard unit: operand forwarding, one-cycle load-use stall and
// one-cycle IF flush on a taken branch/jump resolved in ID.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module exe_hazard_unit
  import exe_hazard_unit_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  exe_hazard_unit_if.slave hif
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  fwd_e      fwda_sel;
  fwd_e      fwdb_sel;
  hz_state_e state_q;
  hz_state_e state_d;
  logic      load_use;

  fwd_select u_fwd_a (
    .src       (hif.id_rs),
    .exe_rn    (hif.exe_rn),
    .exe_wreg  (hif.exe_wreg),
    .exe_m2reg (hif.exe_m2reg),
    .mem_rn    (hif.mem_rn),
    .mem_wreg  (hif.mem_wreg),
    .mem_m2reg (hif.mem_m2reg),
    .fwd       (fwda_sel)
  );

  fwd_select u_fwd_b (
    .src       (hif.id_rt),
    .exe_rn    (hif.exe_rn),
    .exe_wreg  (hif.exe_wreg),
    .exe_m2reg (hif.exe_m2reg),
    .mem_rn    (hif.mem_rn),
    .mem_wreg  (hif.mem_wreg),
    .mem_m2reg (hif.mem_m2reg),
    .fwd       (fwdb_sel)
  );

  assign hif.fwda = fwda_sel;
  assign hif.fwdb = fwdb_sel;

  // Load in EXE whose destination is read by the instruction in ID.
  always_comb begin
    load_use = hif.exe_wreg && hif.exe_m2reg &&
               ((hif.id_use_rs && reg_hit(hif.exe_rn, hif.id_rs)) ||
                (hif.id_use_rt && reg_hit(hif.exe_rn, hif.id_rt)));
  end

  // State register; reset abandons any pending stall or flush.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state and stall/flush controls; outputs held inactive during clr.
  always_comb begin
    state_d       = state_q;
    hif.wpcir     = 1'b1;
    hif.id_bubble = 1'b0;
    hif.if_flush  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_use) begin
          state_d       = ST_LSTALL;
          hif.wpcir     = clr;
          hif.id_bubble = !clr;
        end else if (hif.id_branch_taken) begin
          state_d      = ST_FLUSH;
          hif.if_flush = !clr;
        end
      end
      ST_LSTALL: state_d = ST_RUN;
      ST_FLUSH:  state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Count entries into LSTALL / FLUSH, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == ST_RUN && state_d == ST_LSTALL && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (state_q == ST_RUN && state_d == ST_FLUSH && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_exe_hazard_unit.sv
// Self-checking bench for exe_hazard_unit: directed scenarios followed by
// random stage traffic, compared against a rule-level reference model.
module tb_exe_hazard_unit;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  // Reference-model memory of what the unit did in the previous cycle.
  bit   prev_stalled;
  bit   prev_flushed;
  int   stalls_seen;
  int   flushes_seen;

  exe_hazard_unit_if hif ();

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  exe_hazard_unit dut (
    .clk (clk),
    .clr (clr),
    .hif (hif)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_fwd(input int src);
    if (src != 0 && hif.exe_wreg && !hif.exe_m2reg && hif.exe_rn == src) return 1;
    if (src != 0 && hif.mem_wreg && hif.mem_rn == src) return hif.mem_m2reg ? 3 : 2;
    return 0;
  endfunction

  function automatic bit ref_load_use();
    return hif.exe_wreg && hif.exe_m2reg && hif.exe_rn != 0 &&
           ((hif.id_use_rs && hif.exe_rn == hif.id_rs) ||
            (hif.id_use_rt && hif.exe_rn == hif.id_rt));
  endfunction

  task automatic idle();
    hif.id_rs = '0; hif.id_rt = '0; hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
    hif.exe_rn = '0; hif.exe_wreg = 1'b0; hif.exe_m2reg = 1'b0;
    hif.mem_rn = '0; hif.mem_wreg = 1'b0; hif.mem_m2reg = 1'b0;
    hif.id_branch_taken = 1'b0;
  endtask

  // Settle the current inputs, check every output, then advance one clock.
  task automatic cycle(input string tag);
    bit busy, stall, flush;
    #1;
    busy  = prev_stalled || prev_flushed;
    stall = !clr && !busy && ref_load_use();
    flush = !clr && !busy && !ref_load_use() && hif.id_branch_taken;
    chk({tag, "_fwda"},   16'(hif.fwda), 16'(ref_fwd(int'(hif.id_rs))));
    chk({tag, "_fwdb"},   16'(hif.fwdb), 16'(ref_fwd(int'(hif.id_rt))));
    chk({tag, "_wpcir"},  16'(hif.wpcir), 16'(!stall));
    chk({tag, "_bubble"}, 16'(hif.id_bubble), 16'(stall));
    chk({tag, "_flush"},  16'(hif.if_flush), 16'(flush));
`ifdef HAZARD_STATS_EN
    chk({tag, "_scnt"}, stall_cnt, 16'(stalls_seen));
    chk({tag, "_fcnt"}, flush_cnt, 16'(flushes_seen));
`endif
    @(posedge clk);
    if (clr) begin
      prev_stalled = 1'b0; prev_flushed = 1'b0;
      stalls_seen = 0; flushes_seen = 0;
    end else begin
      prev_stalled = stall;
      prev_flushed = flush;
      if (stall && stalls_seen < 65535) stalls_seen++;
      if (flush && flushes_seen < 65535) flushes_seen++;
    end
    @(negedge clk);
  endtask

  initial begin
    prev_stalled = 1'b0; prev_flushed = 1'b0;
    stalls_seen = 0; flushes_seen = 0;
    idle();
    clr = 1'b1;
    // Reset state
    #2;
    chk("rst_wpcir",  16'(hif.wpcir), 16'd1);
    chk("rst_bubble", 16'(hif.id_bubble), 16'd0);
    chk("rst_flush",  16'(hif.if_flush), 16'd0);
    @(negedge clk);
    clr = 1'b0;
    cycle("idle");

    // EXE ALU forward to rs
    hif.id_rs = 5'd5; hif.id_use_rs = 1'b1;
    hif.exe_rn = 5'd5; hif.exe_wreg = 1'b1;
    #1;
    chk("exe_fwd_a", 16'(hif.fwda), 16'd1);
    chk("exe_fwd_wpcir", 16'(hif.wpcir), 16'd1);
    cycle("exe_fwd");

    // Load-use on rt: one stall, then load data forwarded from MEM
    idle();
    hif.id_rt = 5'd7; hif.id_use_rt = 1'b1;
    hif.exe_rn = 5'd7; hif.exe_wreg = 1'b1; hif.exe_m2reg = 1'b1;
    #1;
    chk("lu_wpcir",  16'(hif.wpcir), 16'd0);
    chk("lu_bubble", 16'(hif.id_bubble), 16'd1);
    cycle("lu");
    hif.exe_rn = '0; hif.exe_wreg = 1'b0; hif.exe_m2reg = 1'b0;
    hif.mem_rn = 5'd7; hif.mem_wreg = 1'b1; hif.mem_m2reg = 1'b1;
    #1;
    chk("lu2_fwdb",  16'(hif.fwdb), 16'd3);
    chk("lu2_wpcir", 16'(hif.wpcir), 16'd1);
    cycle("lu2");

    // EXE beats MEM on the same register
    idle();
    hif.id_rs = 5'd9; hif.id_use_rs = 1'b1;
    hif.exe_rn = 5'd9; hif.exe_wreg = 1'b1;
    hif.mem_rn = 5'd9; hif.mem_wreg = 1'b1;
    #1;
    chk("prio_fwda", 16'(hif.fwda), 16'd1);
    cycle("prio");

    // Register 0 never stalls or forwards
    idle();
    hif.id_use_rs = 1'b1;
    hif.exe_wreg = 1'b1; hif.exe_m2reg = 1'b1;
    hif.mem_wreg = 1'b1;
    #1;
    chk("r0_fwda",  16'(hif.fwda), 16'd0);
    chk("r0_wpcir", 16'(hif.wpcir), 16'd1);
    cycle("r0");

    // Taken branch: single-cycle flush, held branch ignored next cycle
    idle();
    hif.id_branch_taken = 1'b1;
    #1;
    chk("br_flush", 16'(hif.if_flush), 16'd1);
    cycle("br");
    #1;
    chk("br2_flush", 16'(hif.if_flush), 16'd0);
    cycle("br2");
    hif.id_branch_taken = 1'b0;
    cycle("br3");

    // Load-use beats a branch in the same cycle
    hif.id_rs = 5'd3; hif.id_use_rs = 1'b1;
    hif.exe_rn = 5'd3; hif.exe_wreg = 1'b1; hif.exe_m2reg = 1'b1;
    hif.id_branch_taken = 1'b1;
    cycle("lu_br");
    cycle("lu_br2");
    idle();
    cycle("lu_br3");

    // Reset pulsed mid-LSTALL
    hif.id_rt = 5'd4; hif.id_use_rt = 1'b1;
    hif.exe_rn = 5'd4; hif.exe_wreg = 1'b1; hif.exe_m2reg = 1'b1;
    cycle("pre_rst");
    #2;
    clr = 1'b1;
    #1;
    chk("mid_rst_wpcir",  16'(hif.wpcir), 16'd1);
    chk("mid_rst_bubble", 16'(hif.id_bubble), 16'd0);
`ifdef HAZARD_STATS_EN
    chk("mid_rst_scnt", stall_cnt, 16'd0);
`endif
    prev_stalled = 1'b0; prev_flushed = 1'b0;
    stalls_seen = 0; flushes_seen = 0;
    cycle("in_rst");
    clr = 1'b0;
    idle();
    cycle("post_rst");

    // Random stage traffic
    for (int i = 0; i < 400; i++) begin
      hif.id_rs = 5'($urandom_range(0, 3));
      hif.id_rt = 5'($urandom_range(0, 3));
      hif.id_use_rs = 1'($urandom_range(0, 1));
      hif.id_use_rt = 1'($urandom_range(0, 1));
      hif.exe_rn = 5'($urandom_range(0, 3));
      hif.exe_wreg = 1'($urandom_range(0, 1));
      hif.exe_m2reg = 1'($urandom_range(0, 1));
      hif.mem_rn = 5'($urandom_range(0, 3));
      hif.mem_wreg = 1'($urandom_range(0, 1));
      hif.mem_m2reg = 1'($urandom_range(0, 1));
      hif.id_branch_taken = ($urandom_range(0, 3) == 0);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
